// File: rtl/alu_pkg.sv
// alu_pkg: function codes, FSM states and shift-width helpers for alu_seq; MULTU code is only decoded when ALU_MULTU_EN is defined
package alu_pkg;

    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

    localparam int DEF_WIDTH = 32;
    localparam int SHAMT_W   = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: iterative DIVU (and MULTU when ALU_MULTU_EN is defined) unit owning the FSM, counter and HI/LO
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [5:0]       func_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
    logic             mul_q, mul_d, dz_q, dz_d;
    logic             go, go_mul, last;
    logic [WIDTH:0]   trial, sum;

`ifdef ALU_MULTU_EN
    assign go_mul = func_i == F_MULTU;
`else
    assign go_mul = 1'b0;
`endif

    assign go    = start_i && (func_i == F_DIVU || go_mul);
    assign last  = cnt_q == CNT_W'(WIDTH - 1);
    // acc:quo is the partial remainder with the dividend shifting out of quo, or the partial product shifting right
    assign trial = {acc_q, quo_q[WIDTH-1]} - {1'b0, opb_q};
    assign sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : '0);

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign busy_o     = state_q == S_RUN;
    assign done_o     = state_q == S_DONE;
    assign div_zero_o = dz_q;

    // next state: launch from IDLE, one iteration per RUN cycle, commit HI/LO on the last one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        opb_d   = opb_q;
        mul_d   = mul_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: if (go) begin
                state_d = S_RUN;
                cnt_d   = '0;
                acc_d   = '0;
                quo_d   = a_i;
                opb_d   = b_i;
                mul_d   = go_mul;
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = mul_q ? sum[WIDTH:1] : trial[WIDTH] ? {acc_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
                quo_d = mul_q ? {sum[0], quo_q[WIDTH-1:1]} : {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                if (last) begin
                    state_d = S_DONE;
                    hi_d    = acc_d;
                    lo_d    = quo_d;
                    dz_d    = !mul_q && opb_q == '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state register with synchronous reset that also aborts a running operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            opb_q   <= '0;
            mul_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            opb_q   <= opb_d;
            mul_q   <= mul_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: MIPS-style ALU with registered single-cycle ops and iterative DIVU/MULTU into HI/LO (MULTU gated by ALU_MULTU_EN)
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    input  logic             start,
    output logic [WIDTH-1:0] Output,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0] out_q, out_d, hi, lo;

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .reset      (reset),
        .a_i        (dataA),
        .b_i        (dataB),
        .func_i     (Signal),
        .start_i    (start),
        .hi_o       (hi),
        .lo_o       (lo),
        .busy_o     (busy),
        .done_o     (done),
        .div_zero_o (div_zero)
    );

    assign Output = out_q;

    // single-cycle result select; multi-cycle and unknown codes read as zero
    always_comb begin
        out_d = '0;
        case (Signal)
            F_AND:   out_d = dataA & dataB;
            F_OR:    out_d = dataA | dataB;
            F_ADD:   out_d = dataA + dataB;
            F_SUB:   out_d = dataA - dataB;
            F_SLT:   out_d = WIDTH'($signed(dataA) < $signed(dataB));
            F_SRL:   out_d = dataA >> dataB[SH_W-1:0];
            F_MFHI:  out_d = hi;
            F_MFLO:  out_d = lo;
            default: out_d = '0;
        endcase
    end

    // registered result
    always_ff @(posedge clk) begin
        if (reset) out_q <= '0;
        else       out_q <= out_d;
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with a cycle-level reference model (MULTU expectations follow ALU_MULTU_EN)
module tb_alu_seq;

    localparam int W = 32;
`ifdef ALU_MULTU_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] out;
        logic         busy;
        logic         done;
        logic         dz;
        string        nm;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] dataA = '0;
    logic [W-1:0] dataB = '0;
    logic [5:0]   Signal = '0;
    logic         start = 1'b0;
    logic [W-1:0] Output;
    logic         busy, done, div_zero;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // model: architectural HI/LO, result waiting to commit, RUN edges still to come, done pulse
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic         m_dz = 1'b0, p_dz = 1'b0, m_done = 1'b0;
    int           m_left = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .dataA    (dataA),
        .dataB    (dataB),
        .Signal   (Signal),
        .start    (start),
        .Output   (Output),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endfunction

    function automatic logic [W-1:0] ref_out(logic [5:0] sig, logic [W-1:0] a, logic [W-1:0] b);
        case (sig)
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd42:   return ($signed(a) < $signed(b)) ? 1 : 0;
            6'd2:    return a >> (b % W);
            6'd16:   return m_hi;
            6'd18:   return m_lo;
            default: return '0;
        endcase
    endfunction

    // one clock: present inputs, let the edge happen, advance the model and queue the expected response
    task automatic step(input logic [5:0] sig, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic st, input logic rs, input string nm);
        exp_t        e;
        logic [63:0] prod;
        @(negedge clk);
        Signal = sig;
        dataA  = a;
        dataB  = b;
        start  = st;
        reset  = rs;
        @(posedge clk);
        if (rs) begin
            e.out = '0;
            m_hi = '0; m_lo = '0; m_dz = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            e.out = ref_out(sig, a, b);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (st && sig == 6'd27) begin
                p_hi = (b == 0) ? a : a % b;
                p_lo = (b == 0) ? '1 : a / b;
                p_dz = (b == 0);
                m_left = W;
            end else if (st && sig == 6'd25 && MUL_EN) begin
                prod = 64'(a) * 64'(b);
                p_hi = prod[63:32];
                p_lo = prod[31:0];
                p_dz = 1'b0;
                m_left = W;
            end
        end
        e.busy = m_left > 0;
        e.done = m_done;
        e.dz   = m_dz;
        e.nm   = nm;
        #1 exp_q.push_back(e);
    endtask

    // monitor: pops one expectation per cycle mid-cycle, away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.nm, ".out"}, Output, e.out);
                chk({e.nm, ".busy"}, W'(busy), W'(e.busy));
                chk({e.nm, ".done"}, W'(done), W'(e.done));
                chk({e.nm, ".div_zero"}, W'(div_zero), W'(e.dz));
            end
        end
    end

    logic [5:0] codes [12] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd16, 6'd18, 6'd27, 6'd25, 6'd0, 6'd63};

    initial begin
        step(6'd32, 0, 0, 0, 1, "reset");
        step(6'd32, 0, 0, 0, 1, "reset");
        step(6'd16, 0, 0, 0, 0, "mfhi_rst");
        step(6'd32, 7, 5, 0, 0, "add");
        step(6'd34, 5, 7, 0, 0, "sub");
        step(6'd42, 32'hFFFFFFFF, 1, 0, 0, "slt_neg");
        step(6'd42, 1, 32'hFFFFFFFF, 0, 0, "slt_pos");
        step(6'd36, 32'hF0F0, 32'h0FF0, 0, 0, "and");
        step(6'd37, 32'hF0F0, 32'h0FF0, 0, 0, "or");
        step(6'd2, 32'h80000000, 33, 0, 0, "srl33");
        step(6'd63, 32'h1234, 32'h5678, 0, 0, "unknown");
        // divide by zero, then a normal divide that clears the flag
        step(6'd27, 9, 0, 1, 0, "divu9_0");
        for (int i = 0; i < W; i++) step(6'd32, 1, 1, 1, 0, "div0_run");
        step(6'd16, 0, 0, 0, 0, "div0_hi");
        step(6'd18, 0, 0, 0, 0, "div0_lo");
        step(6'd27, 9, 3, 1, 0, "divu9_3");
        for (int i = 0; i < W; i++) step(6'd18, 0, 0, 0, 0, "div3_run");
        step(6'd18, 0, 0, 0, 0, "div3_lo");
        // 100/7 with ignored restarts, ADD and stale MFLO mid-run
        step(6'd27, 100, 7, 1, 0, "divu100_7");
        for (int i = 0; i < W; i++)
            step(i % 3 == 0 ? 6'd27 : i % 3 == 1 ? 6'd18 : 6'd32, 1, 1, 1, 0, "div7_run");
        step(6'd16, 0, 0, 1, 0, "div7_hi");
        step(6'd18, 0, 0, 0, 0, "div7_lo");
        step(6'd25, 32'hFFFFFFFF, 2, 1, 0, "multu");
        for (int i = 0; i < W; i++) step(6'd25, 3, 3, 0, 0, "mul_run");
        step(6'd16, 0, 0, 0, 0, "mul_hi");
        step(6'd18, 0, 0, 0, 0, "mul_lo");
        // reset in the middle of an iteration
        step(6'd27, 1000, 3, 1, 0, "divu_abort");
        for (int i = 0; i < 10; i++) step(6'd32, i, 2, 0, 0, "abort_run");
        step(6'd32, 1, 1, 0, 1, "abort_rst");
        step(6'd16, 0, 0, 0, 0, "abort_hi");
        step(6'd18, 0, 0, 0, 0, "abort_lo");
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            step(codes[$urandom_range(0, 11)], a, b, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 199) == 0, "rand");
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
